// File: rtl/led_req_arbiter.sv
// led_req_arbiter: round-robin sharing of four LEDs with dwell, one-cycle blank gap and idle running light; define LED_PWM_EN for PWM dimming
module led_req_arbiter #(
    parameter int NREQ      = 3,
    parameter int DWELL_CYC = 25_000_000,
    parameter int STEP_CYC  = 12_500_000,
    parameter int PWM_DUTY  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] pat,
    output logic [NREQ-1:0]   grant,
    output logic [3:0]        led,
    output logic              busy
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int DW = DWELL_CYC > 1 ? $clog2(DWELL_CYC) : 1;
    localparam int SW = STEP_CYC > 1 ? $clog2(STEP_CYC) : 1;
    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
    state_t          state_q;
    logic [PW-1:0]   ptr_q, owner_q, win_d, ptr_d;
    logic [NREQ-1:0] grant_q;
    logic [DW-1:0]   dwell_q;
    logic [SW-1:0]   step_q;
    logic [3:0]      led_q, idle_q, idle_d, led_d;
    logic            busy_q, go_show, hold, rel, dwell_end, step_end, lit;
`ifdef LED_PWM_EN
    localparam logic [8:0] DUTY = 9'(PWM_DUTY);
    logic [7:0] pwm_q;
    always_ff @(posedge clk) pwm_q <= rst ? 8'd0 : pwm_q + 8'd1;
    assign lit = {1'b0, pwm_q} < DUTY;
`else
    assign lit = 1'b1;
`endif
    // Scan downward so the lowest offset from ptr wins the last assignment.
    always_comb begin
        int j;
        j = 0;
        win_d = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            j = j >= NREQ ? j - NREQ : j;
            win_d = req[PW'(j)] ? PW'(j) : win_d;
        end
    end
    always_comb begin
        dwell_end = dwell_q == DW'(DWELL_CYC - 1);
        step_end  = step_q == SW'(STEP_CYC - 1);
        go_show   = state_q != SHOW && |req;
        hold      = state_q == SHOW && req[owner_q] && !(dwell_end && |(req & ~grant_q));
        rel       = state_q == SHOW && !hold;
        ptr_d     = rel ? (owner_q == PW'(NREQ - 1) ? '0 : owner_q + PW'(1)) : ptr_q;
        idle_d    = state_q != IDLE ? 4'b0001 : step_end ? {idle_q[2:0], idle_q[3]} : idle_q;
        led_d     = go_show ? pat[{win_d, 2'b00} +: 4] : hold ? pat[{owner_q, 2'b00} +: 4] : rel ? 4'b0000 : idle_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            dwell_q <= '0;
            step_q  <= '0;
            idle_q  <= 4'b0001;
            led_q   <= 4'b0001;
            busy_q  <= 1'b0;
        end else begin
            state_q <= go_show || hold ? SHOW : rel ? GAP : IDLE;
            ptr_q   <= ptr_d;
            owner_q <= go_show ? win_d : owner_q;
            grant_q <= go_show ? NREQ'(1) << win_d : hold ? grant_q : '0;
            dwell_q <= hold && !dwell_end ? dwell_q + DW'(1) : '0;
            step_q  <= state_q == IDLE && !step_end ? step_q + SW'(1) : '0;
            idle_q  <= idle_d;
            led_q   <= led_d & {4{lit}};
            busy_q  <= go_show || hold || rel;
        end
    end
    assign grant = grant_q;
    assign led   = led_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_led_req_arbiter.sv
// tb_led_req_arbiter: directed vector table plus hand sequences for idle stepping, solo hold, contention and resets
module tb_led_req_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [11:0] pat;
    logic [2:0]  grant;
    logic [3:0]  led;
    logic        busy;
    int          errors = 0;
    int          checks = 0;
    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [11:0] pat;
        logic [2:0]  grant;
        logic [3:0]  led;
        logic        busy;
    } vec_t;
    vec_t vecs[13];
    led_req_arbiter #(.NREQ(3), .DWELL_CYC(8), .STEP_CYC(4), .PWM_DUTY(64)) dut (
        .clk(clk), .rst(rst), .req(req), .pat(pat), .grant(grant), .led(led), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    initial begin
        logic [3:0] e;
        int cnt;
        vecs[0]  = '{1'b1, 3'b000, 12'hCA5, 3'b000, 4'b0001, 1'b0};
        vecs[1]  = '{1'b0, 3'b010, 12'hCA5, 3'b010, 4'b1010, 1'b1};
        vecs[2]  = '{1'b0, 3'b000, 12'hCA5, 3'b000, 4'b0000, 1'b1};
        vecs[3]  = '{1'b0, 3'b000, 12'hCA5, 3'b000, 4'b0001, 1'b0};
        vecs[4]  = '{1'b0, 3'b011, 12'hCA5, 3'b001, 4'b0101, 1'b1};
        vecs[5]  = '{1'b0, 3'b011, 12'hCA5, 3'b001, 4'b0101, 1'b1};
        vecs[6]  = '{1'b0, 3'b010, 12'hCA5, 3'b000, 4'b0000, 1'b1};
        vecs[7]  = '{1'b0, 3'b010, 12'hCA5, 3'b010, 4'b1010, 1'b1};
        vecs[8]  = '{1'b1, 3'b010, 12'hCA5, 3'b000, 4'b0001, 1'b0};
        vecs[9]  = '{1'b0, 3'b111, 12'hCA5, 3'b001, 4'b0101, 1'b1};
        vecs[10] = '{1'b0, 3'b111, 12'hCAF, 3'b001, 4'b1111, 1'b1};
        vecs[11] = '{1'b0, 3'b000, 12'hCAF, 3'b000, 4'b0000, 1'b1};
        vecs[12] = '{1'b0, 3'b100, 12'hCA5, 3'b100, 4'b1100, 1'b1};
        rst = 1'b1;
        req = 3'b000;
        pat = 12'hCA5;
        repeat (5) tick();
        check("rst_led", led, 4'b0001);
        check("rst_grant", grant, 3'b000);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            e = 4'b0001 << ((c / 4) % 4);
            check("idle_led", led, e);
            check("idle_busy", busy, 1'b0);
        end
        for (int i = 0; i < 13; i++) begin
            rst = vecs[i].rst;
            req = vecs[i].req;
            pat = vecs[i].pat;
            tick();
            check($sformatf("vec%0d_grant", i), grant, vecs[i].grant);
            check($sformatf("vec%0d_led", i), led, vecs[i].led);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
        end
        rst = 1'b1;
        req = 3'b000;
        pat = 12'hCA5;
        tick();
        rst = 1'b0;
        req = 3'b010;
        for (int c = 0; c < 30; c++) begin
            tick();
            check("solo_grant", grant, 3'b010);
            check("solo_led", led, 4'b1010);
        end
        rst = 1'b1;
        req = 3'b000;
        tick();
        rst = 1'b0;
        req = 3'b001;
        repeat (4) tick();
        check("early_grant", grant, 3'b001);
        req = 3'b000;
        tick();
        check("early_gap_grant", grant, 3'b000);
        check("early_gap_led", led, 4'b0000);
        check("early_gap_busy", busy, 1'b1);
        tick();
        check("early_idle_led", led, 4'b0001);
        check("early_idle_busy", busy, 1'b0);
        req = 3'b001;
        repeat (6) tick();
        check("mid_pre_grant", grant, 3'b001);
        rst = 1'b1;
        tick();
        check("mid_rst_grant", grant, 3'b000);
        check("mid_rst_led", led, 4'b0001);
        check("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        req = 3'b111;
        tick();
        check("mid_after_grant", grant, 3'b001);
        rst = 1'b1;
        req = 3'b000;
        tick();
        rst = 1'b0;
        req = 3'b101;
        for (int c = 0; c < 54; c++) begin
            int ph;
            tick();
            ph = c % 18;
            check("cont_grant", grant, ph < 8 ? 3'b001 : ph == 8 ? 3'b000 : ph < 17 ? 3'b100 : 3'b000);
            check("cont_led", led, ph < 8 ? 4'b0101 : ph == 8 ? 4'b0000 : ph < 17 ? 4'b1100 : 4'b0000);
        end
`ifdef LED_PWM_EN
        rst = 1'b1;
        req = 3'b000;
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 256; c++) begin
            tick();
            cnt += (|led) ? 1 : 0;
        end
        check("pwm_lit", cnt, 64);
`else
        cnt = 0;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_req_arbiter.md
# led_req_arbiter

Round-robin arbiter that shares the board's four user LEDs among `NREQ` independent requesters. Each requester supplies a 4-bit pattern and a request.
- The granted requester drives the LEDs for a minimum dwell time.
- A one-cycle blank gap separates owners.
- With no requests pending, the block shows a running-light idle pattern.

It sits between application logic and the top-level `led[3:0]` pins, replacing direct LED drive.

## Interface
- `NREQ`, 3: number of requesters; legal range 2..8.
- `DWELL_CYC`, 25_000_000: minimum cycles an owner holds the LEDs while others wait; must be ≥ 2.
- `STEP_CYC`, 12_500_000: cycles per idle running-light step; must be ≥ 1.
- `PWM_DUTY`, 128: brightness duty in 1/256 units. Used only with `LED_PWM_EN`.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NREQ`: per-requester request level; held high while the LEDs are wanted.
- `pat` in 4*`NREQ`: requester i's pattern is `pat[4i+3:4i]`; sampled live every cycle.
- `grant` out `NREQ`: registered one-hot owner indication; all zero when no owner.
- `led` out 4: registered LED drive, active-high.
- `busy` out 1: registered; high in any state other than IDLE.

## Operation
- States: IDLE, SHOW, GAP.
- IDLE:
  - `led` rotates one-hot 0001→0010→0100→1000→0001.
  - The step counter counts 0..`STEP_CYC`-1 and rotates on terminal count.
  - If `|req`, go to SHOW. The winner is the first asserted `req` searching upward from pointer `ptr`, wrapping at `NREQ`.
- SHOW:
  - `grant` is one-hot for the owner.
  - `led` is loaded each cycle from the owner's `pat`.
  - The dwell counter counts 0..`DWELL_CYC`-1.
- SHOW exit and hold rules:
  - Release when `req[owner]`=0 (any count).
  - Release when the count = `DWELL_CYC`-1 and any other `req` is high.
  - At `DWELL_CYC`-1 with only the owner requesting, the counter reloads 0 and the grant is held without a gap.
- On release:
  - `ptr` ← (owner+1) mod `NREQ`.
  - Next state is GAP.
- GAP (exactly 1 cycle):
  - `grant`=0, `led`=0000.
  - Next state is SHOW with a new winner (using the updated `ptr`) if `|req`, else IDLE.
- Entering IDLE resets the step counter and sets `led`=0001.
- Entering SHOW clears the dwell counter.
- Counter widths are `$clog2` of the respective parameter, with a minimum of 1 bit. No counter may overflow or wrap except at its stated terminal count.
- Request changes in GAP are evaluated in that same cycle. A requester that drops `req` before winning is simply skipped.

## Timing
- Reset values (cycle after `rst` sampled high): state=IDLE, `ptr`=0, `grant`=0, `led`=0001, `busy`=0, all counters 0. This applies mid-operation too.
- `req` rising in IDLE at cycle t → `grant`/`busy` valid at t+1. `led` at t+1 = `pat[owner]` sampled at t.
- `pat` change during SHOW appears on `led` 1 cycle later.
- Owner drops `req` at t → GAP at t+1 (`grant`=0) → next owner, or IDLE, at t+2.
- Contended dwell: the owner holds exactly `DWELL_CYC` cycles, then 1 gap cycle.
- Idle step: `led` changes every `STEP_CYC` cycles, first change `STEP_CYC` cycles after entering IDLE.

## Configuration
- Macro `LED_PWM_EN`:
  - Defined: an 8-bit free-running PWM counter (reset 0) gates the output. `led` = next LED value AND {4{pwm_cnt < `PWM_DUTY`}}, applied in the same output register, so latency is unchanged. `PWM_DUTY`=0 blanks, 255 gives 255/256.
  - Undefined: no PWM logic; `led` driven ungated; `PWM_DUTY` ignored.

## Test plan
Benches use `NREQ`=3, `DWELL_CYC`=8, `STEP_CYC`=4.
- Reset: `rst`=1 for 5 cycles → `led`=0001, `grant`=000, `busy`=0. After release, `led`=0010 at the 4th cycle, 0100 at the 8th, 0001 again at the 16th.
- Solo: `req`=010, `pat[7:4]`=1010 held 30 cycles → `grant`=010, `led`=1010 one cycle later, no gap ever.
- Contention: `req`=101 from IDLE → `grant` 001 ×8, gap (000/0000) ×1, 100 ×8, gap, 001 …
- Early release: the owner drops `req` at dwell count 3 with no others pending → GAP next cycle, then IDLE with `led`=0001, `busy`=0.
- Reset mid-SHOW: `rst` at dwell count 5 → next cycle `grant`=000, `led`=0001, `ptr`=0. Then `req`=111 → `grant`=001.
- `LED_PWM_EN`, `PWM_DUTY`=64, idle: the lit LED bit is high for exactly 64 of every 256 cycles.
